// File: rtl/alu_digit_serial.sv
// rtl/alu_digit_serial.sv - digit-serial RV32I ALU with start/done handshake
// Add/sub/logic/compare run one digit per cycle; shifts step by DIGIT or by 1.
module alu_digit_serial #(
  parameter int XLEN  = 32,
  parameter int DIGIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rd
);

  localparam int N  = XLEN / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_SHIFT} state_t;

  state_t          state_q;
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, rd_q;
  logic            carry_q, ready_q, done_q;
  logic [CW-1:0]   cnt_q;
  logic [SW-1:0]   rem_q;

  logic [DIGIT-1:0] a_dig, b_dig, b_eff, r_dig;
  logic [DIGIT:0]   sum;
  logic             inv_b, is_cmp, last_dig, ovf, lt, ltu;
  logic [XLEN-1:0]  rd_shift, rd_fin, work_nx;
  logic [SW-1:0]    rem_nx;

  assign ready = ready_q;
  assign busy  = ~ready_q;
  assign done  = done_q;
  assign rd    = rd_q;

  // One digit of the add/sub/logic datapath; A and B are consumed from their LSB end.
  always_comb begin
    inv_b    = (op_q == OP_SUB) || (op_q == OP_SLT) || (op_q == OP_SLTU);
    is_cmp   = (op_q == OP_SLT) || (op_q == OP_SLTU);
    a_dig    = a_q[DIGIT-1:0];
    b_dig    = b_q[DIGIT-1:0];
    b_eff    = inv_b ? ~b_dig : b_dig;
    sum      = {1'b0, a_dig} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry_q};
    last_dig = (cnt_q == CW'(N - 1));
    ovf      = (a_dig[DIGIT-1] != b_dig[DIGIT-1]) && (sum[DIGIT-1] != a_dig[DIGIT-1]);
    lt       = sum[DIGIT-1] ^ ovf;
    ltu      = ~sum[DIGIT];
    case (op_q)
      OP_ADD, OP_SUB: r_dig = sum[DIGIT-1:0];
      OP_XOR:         r_dig = a_dig ^ b_dig;
      OP_OR:          r_dig = a_dig | b_dig;
      OP_AND:         r_dig = a_dig & b_dig;
      default:        r_dig = '0;
    endcase
    rd_shift = (rd_q >> DIGIT) | (XLEN'(r_dig) << (XLEN - DIGIT));
    case (op_q)
      OP_SLT:  rd_fin = {{(XLEN-1){1'b0}}, lt};
      OP_SLTU: rd_fin = {{(XLEN-1){1'b0}}, ltu};
      OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND: rd_fin = rd_shift;
      default: rd_fin = '0;
    endcase
  end

  // Shift step: coarse by DIGIT while enough remains, then single-bit steps.
  always_comb begin
    work_nx = a_q;
    rem_nx  = rem_q;
    if (rem_q != '0) begin
      if (32'(rem_q) >= 32'(DIGIT)) begin
        case (op_q)
          OP_SLL:  work_nx = a_q << DIGIT;
          OP_SRA:  work_nx = $unsigned($signed(a_q) >>> DIGIT);
          default: work_nx = a_q >> DIGIT;
        endcase
        rem_nx = rem_q - SW'(DIGIT);
      end else begin
        case (op_q)
          OP_SLL:  work_nx = a_q << 1;
          OP_SRA:  work_nx = $unsigned($signed(a_q) >>> 1);
          default: work_nx = a_q >> 1;
        endcase
        rem_nx = rem_q - SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            a_q     <= rs1;
            b_q     <= rs2;
            carry_q <= (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
            cnt_q   <= '0;
            rem_q   <= rs2[SW-1:0];
            ready_q <= 1'b0;
            state_q <= (op == OP_SLL || op == OP_SRL || op == OP_SRA) ? S_SHIFT : S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= sum[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (last_dig) begin
            rd_q    <= rd_fin;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (!is_cmp) begin
            rd_q <= rd_shift;
          end
        end
        S_SHIFT: begin
          a_q   <= work_nx;
          rem_q <= rem_nx;
          if (rem_nx == '0) begin
            rd_q    <= work_nx;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_digit_serial.sv
// tb/tb_alu_digit_serial.sv - directed vectors and handshake/reset sequences for alu_digit_serial
// Instances: u0 DIGIT=4, u1 DIGIT=1, u2 DIGIT=32.
module tb_alu_digit_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start0, start1, start2;
  logic [3:0]  op0, op1, op2;
  logic [31:0] a0, a1, a2, b0, b1, b2;
  logic        ready0, ready1, ready2, busy0, busy1, busy2, done0, done1, done2;
  logic [31:0] rd0, rd1, rd2;

  alu_digit_serial #(.XLEN(32), .DIGIT(4)) u0 (
    .clk(clk), .rst(rst), .start(start0), .op(op0), .rs1(a0), .rs2(b0),
    .ready(ready0), .busy(busy0), .done(done0), .rd(rd0));
  alu_digit_serial #(.XLEN(32), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .op(op1), .rs1(a1), .rs2(b1),
    .ready(ready1), .busy(busy1), .done(done1), .rd(rd1));
  alu_digit_serial #(.XLEN(32), .DIGIT(32)) u2 (
    .clk(clk), .rst(rst), .start(start2), .op(op2), .rs1(a2), .rs2(b2),
    .ready(ready2), .busy(busy2), .done(done2), .rd(rd2));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rd;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int u, input logic s, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    case (u)
      0: begin start0 = s; op0 = o; a0 = a; b0 = b; end
      1: begin start1 = s; op1 = o; a1 = a; b1 = b; end
      default: begin start2 = s; op2 = o; a2 = a; b2 = b; end
    endcase
  endtask

  function automatic logic get_done(input int u);
    return (u == 0) ? done0 : (u == 1) ? done1 : done2;
  endfunction

  function automatic logic [31:0] get_rd(input int u);
    return (u == 0) ? rd0 : (u == 1) ? rd1 : rd2;
  endfunction

  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (o)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> sh;
      4'b1101: return $unsigned($signed(a) >>> sh);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] o, input logic [31:0] b, input int d);
    int sh, l;
    if (o == 4'b0001 || o == 4'b0101 || o == 4'b1101) begin
      sh = int'(b[4:0]);
      l  = sh / d + sh % d;
      return (l < 1) ? 1 : l;
    end
    return 32 / d;
  endfunction

  // Presents one start just before edge k and returns #1 after edge k.
  task automatic launch(input int u, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive(u, 1'b1, o, a, b);
    @(posedge clk);
    #1;
    drive(u, 1'b0, o, a, b);
  endtask

  task automatic wait_done(input int u, output int lat);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (get_done(u)) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_op(input int u, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_rd, input int exp_l, input string name);
    int lat;
    launch(u, o, a, b);
    wait_done(u, lat);
    check({name, " latency"}, 32'(lat), 32'(exp_l));
    check({name, " rd"}, get_rd(u), exp_rd);
    @(posedge clk);
    #1;
    check({name, " done single pulse"}, {31'd0, get_done(u)}, 32'd0);
  endtask

  initial begin
    int lat, lat2, extra;
    logic [3:0] rops[11];
    logic [3:0] o;
    logic [31:0] ra, rb;
    int dig[3];

    vecs[0]  = '{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 8};
    vecs[1]  = '{4'h8, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 8};
    vecs[2]  = '{4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 8};
    vecs[3]  = '{4'h3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 8};
    vecs[4]  = '{4'h2, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 8};
    vecs[5]  = '{4'hD, 32'h80000000, 32'h00000007, 32'hFF000000, 4};
    vecs[6]  = '{4'h5, 32'h80000000, 32'h00000007, 32'h01000000, 4};
    vecs[7]  = '{4'h1, 32'h00000001, 32'h0000001F, 32'h80000000, 10};
    vecs[8]  = '{4'h1, 32'h12345678, 32'h00000000, 32'h12345678, 1};
    vecs[9]  = '{4'h1, 32'h00000001, 32'hFFFFFFE3, 32'h00000008, 3};
    vecs[10] = '{4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 8};
    vecs[11] = '{4'h6, 32'h0000FFFF, 32'h00FF0000, 32'h00FFFFFF, 8};
    vecs[12] = '{4'h7, 32'h12345678, 32'h0F0F0F0F, 32'h02040608, 8};
    vecs[13] = '{4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 8};
    vecs[14] = '{4'h3, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 8};
    vecs[15] = '{4'hD, 32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 1};
    vecs[16] = '{4'h5, 32'h80000000, 32'h0000001F, 32'h00000001, 10};
    vecs[17] = '{4'hF, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 8};

    rops = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7, 4'hA};
    dig  = '{4, 1, 32};

    for (int u = 0; u < 3; u++) drive(u, 1'b0, 4'h0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset rd", rd0, 32'h0);
    check("reset ready", {31'd0, ready0}, 32'd1);
    check("reset busy", {31'd0, busy0}, 32'd0);
    check("reset done", {31'd0, done0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++)
      run_op(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].lat, $sformatf("vec%0d", i));

    // Starts while busy and operand changes after acceptance must be ignored.
    launch(0, 4'h0, 32'h11111111, 32'h22222222);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      drive(0, (c >= 2 && c <= 4), 4'h8, 32'hDEADBEEF, 32'h0BADF00D);
      @(posedge clk);
      #1;
      if (c == 4) check("busy mid-op", {31'd0, busy0}, 32'd1);
      if (done0) begin
        lat = c;
        break;
      end
    end
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("ignore-start latency", 32'(lat), 32'd8);
    check("ignore-start rd", rd0, 32'h33333333);
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done0) extra++;
    end
    check("ignore-start no queued done", 32'(extra), 32'd0);
    check("ignore-start ready after", {31'd0, ready0}, 32'd1);

    // Back-to-back: start in the done cycle.
    launch(0, 4'h0, 32'h00000001, 32'h00000002);
    wait_done(0, lat);
    check("b2b first latency", 32'(lat), 32'd8);
    check("b2b first rd", rd0, 32'h00000003);
    drive(0, 1'b1, 4'h8, 32'h0000000A, 32'h00000003);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("b2b first done ended", {31'd0, done0}, 32'd0);
    wait_done(0, lat2);
    check("b2b second latency", 32'(lat2), 32'd8);
    check("b2b second rd", rd0, 32'h00000007);

    // Asynchronous reset mid-ADD.
    launch(0, 4'h0, 32'h12345678, 32'h11111111);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst rd", rd0, 32'h0);
    check("async rst ready", {31'd0, ready0}, 32'd1);
    check("async rst busy", {31'd0, busy0}, 32'd0);
    check("async rst done", {31'd0, done0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done0) extra++;
    end
    check("aborted op no done", 32'(extra), 32'd0);
    run_op(0, 4'h0, 32'h00000064, 32'h000000C8, 32'h0000012C, 8, "post-reset add");

    run_op(1, 4'h0, 32'h00000003, 32'h00000004, 32'h00000007, 32, "d1 add");
    run_op(1, 4'hD, 32'h80000000, 32'h00000005, 32'hFC000000, 5, "d1 sra");
    run_op(2, 4'h0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1, "d32 add");
    run_op(2, 4'h1, 32'h00000001, 32'h0000001F, 32'h80000000, 31, "d32 sll");
    run_op(2, 4'hD, 32'h80000001, 32'h00000000, 32'h80000001, 1, "d32 sra sh0");

    for (int u = 0; u < 3; u++) begin
      for (int i = 0; i < 15; i++) begin
        o  = rops[$urandom_range(0, 10)];
        ra = $urandom;
        rb = $urandom;
        if (i % 4 == 0) rb = ra;
        run_op(u, o, ra, rb, model(o, ra, rb), exp_lat(o, rb, dig[u]),
               $sformatf("rand u%0d i%0d op%h", u, i, o));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_digit_serial.md
Name: alu_digit_serial

Overview:
- Parametrised digit-serial integer ALU for the RV32I execute path. Processes DIGIT bits of the operands per clock, LSB first.
- Supports the full R/I-type ALU op set with a start/done handshake, so the core can trade area for latency at build time.
- Successor to the bit-serial ALU:
  - Generalises operand width and digit width.
  - Adds async reset, a ready/busy indication and variable-latency barrel-stepped shifts.

Parameters:
- XLEN, 32, operand/result width in bits.
- DIGIT, 4, bits processed per cycle. Power of two, 1..XLEN, divides XLEN.
- N (localparam), XLEN/DIGIT, digit count per operand.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- op  input  4  operation code, sampled with start
- rs1  input  XLEN  operand A, sampled with start
- rs2  input  XLEN  operand B / shift amount, sampled with start
- ready  output  1  FSM idle, can accept start
- busy  output  1  operation in progress (inverse of ready)
- done  output  1  one-cycle pulse, rd valid
- rd  output  XLEN  result, held until the next accepted start

Behaviour:
- Op encoding:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011.
  - XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - Any other code: rd=0, latency N.
- Reset (async, any time, including mid-operation):
  - state=IDLE, rd=0, done=0, ready=1, busy=0.
  - Internal carry, counters and operand registers cleared.
  - An aborted operation never produces done.
- States: IDLE, COMPUTE, SHIFT.
- IDLE:
  - ready=1.
  - On start=1, latch op, rs1, rs2 into internal registers; later input changes have no effect.
  - Go to SHIFT for SLL/SRL/SRA, otherwise COMPUTE.
- start while busy=1 is ignored, with no queueing.
- Latency L: start sampled at edge k; done=1 and rd valid during the cycle after edge k+L; FSM is back in IDLE in that same cycle.
- start asserted in the done cycle is accepted (back-to-back, no bubble).
- COMPUTE (ADD/SUB/logic/SLT/SLTU), L = N:
  - Digit counter 0..N-1.
  - Each cycle, combine digit i of A and B and shift the result digit into rd from the MSB end.
  - ADD: ripple carry, initial carry 0.
  - SUB: B inverted, initial carry 1.
  - SLT/SLTU: internally compute A-B as SUB. rd is not updated digit-wise; only the final cycle writes rd.
    - SLTU: rd = {0…, ~carry_out}.
    - SLT: rd = {0…, sign(diff) XOR overflow}, where overflow = (A31 != B31) and (diff31 != A31).
  - Carry out of bit XLEN-1 is discarded for ADD/SUB (mod 2^XLEN).
- SHIFT:
  - sh = rs2[$clog2(XLEN)-1:0]; upper rs2 bits ignored.
  - Working register initialised to rs1.
  - Each cycle: if remaining >= DIGIT, shift by DIGIT; else shift by 1.
  - L = max(1, sh/DIGIT + sh%DIGIT).
  - sh=0: one cycle, rd=rs1.
  - Fill bits: SLL zeros at LSB, SRL zeros at MSB, SRA copies of latched rs1[XLEN-1].
  - DIGIT=1: L = max(1, sh). DIGIT=XLEN: coarse step never taken.
- rd updates only during COMPUTE/SHIFT; stable in IDLE.
- done is high exactly one cycle per accepted start.
- No combinational path from inputs to outputs.

Test Plan (XLEN=32, DIGIT=4 unless noted):
1. ADD rs1=0xFFFFFFFF, rs2=1, start at edge k -> done only in cycle after edge k+8, rd=0x00000000, single pulse.
2. SUB 5-7 -> rd=0xFFFFFFFE, L=8. SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0. SLT 0x7FFFFFFF vs 0x80000000 -> 0.
3. Shifts, rs1=0x80000000:
   - SRA sh=7 -> rd=0xFF000000, L=4.
   - SRL sh=7 -> 0x01000000.
   - SLL rs1=1 sh=31 -> 0x80000000, L=10.
   - sh=0 -> rd=rs1, L=1.
   - rs2=0xFFFFFFE3 -> treated as sh=3.
4. Handshake:
   - start pulsed at cycles 2,3,4 of an ADD -> ignored, result unaffected.
   - Operands changed after acceptance -> no effect.
   - New start in done cycle -> accepted, second done exactly L later.
5. Reset:
   - rst asserted mid-ADD (cycle 3) asynchronously -> rd=0, ready=1 immediately, no done.
   - Next op after release completes normally.
6. Parameter sweep:
   - DIGIT=1: ADD L=32, SRA sh=5 L=5.
   - DIGIT=32: ADD L=1, SLL sh=31 L=31.
   - Random op/operand regression vs golden model, all configs.
